acc_burst_arbiter: RTL and testbench

- Two-requester round-robin scheduler and sequencer for the n-bit registered add/subtract accumulator (inputs A, B, Sel, AddSub; outputs Z, Overflow).
- Each requester sends a burst of signed operands. The block grants one burst at a time and drives the datapath: Sel=0 on the first beat, Sel=1 on later beats.
- Tracks the datapath's 2-register latency and returns one result pulse per burst, carrying the final sum, a sticky overflow flag and the requester ID.

---
 rtl/acc_burst_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_acc_burst_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_burst_arbiter.sv
// Two-requester round-robin burst sequencer for a registered add/subtract accumulator.
// Optional ACC_BURST_ARBITER_BEATCNT_EN adds a saturating per-burst beat count on res_beats.
module acc_burst_arbiter #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [N-1:0] r0_data,
    input  logic         r0_sub,
    input  logic         r0_last,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [N-1:0] r1_data,
    input  logic         r1_sub,
    input  logic         r1_last,
    output logic [N-1:0] acc_a,
    output logic [N-1:0] acc_b,
    output logic         acc_sel,
    output logic         acc_addsub,
    input  logic [N-1:0] acc_z,
    input  logic         acc_ovf,
    output logic         res_valid,
    output logic [N-1:0] res_data,
    output logic         res_ovf,
`ifdef ACC_BURST_ARBITER_BEATCNT_EN
    output logic [7:0]   res_beats,
`endif
    output logic         res_id
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic id;
    } tag_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           ptr_q, ptr_d;
    logic           grant;
    logic           active;
    logic           accept;
    logic           first_beat;
    logic [N-1:0]   beat_data;
    logic           beat_sub;
    logic           beat_last;
    logic [N-1:0]   b_d;
    logic           sub_d;
    logic           sel_d;
    tag_t           tag0_d, tag0_q, tag1_q, tag2_q;
    logic           ovf_acc_q;

    assign acc_a = '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Grant, handshake and issue decode; the first beat is taken in the grant cycle
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        grant      = owner_q;
        active     = 1'b0;
        b_d        = '0;
        sub_d      = 1'b0;
        sel_d      = 1'b1;
        tag0_d     = '0;
        first_beat = (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                active = r0_valid | r1_valid;
                grant  = (r0_valid && r1_valid) ? ptr_q : r1_valid;
            end
            S_BURST: begin
                active = 1'b1;
                grant  = owner_q;
            end
            default: state_d = S_IDLE;
        endcase

        r0_ready  = active & ~grant;
        r1_ready  = active & grant;
        accept    = grant ? (r1_valid & r1_ready) : (r0_valid & r0_ready);
        beat_data = grant ? r1_data : r0_data;
        beat_sub  = grant ? r1_sub  : r0_sub;
        beat_last = grant ? r1_last : r0_last;

        if (accept) begin
            b_d    = beat_data;
            sub_d  = beat_sub;
            sel_d  = ~first_beat;
            tag0_d = '{valid: 1'b1, first: first_beat, last: beat_last, id: grant};
            if (beat_last) begin
                state_d = S_IDLE;
                ptr_d   = ~grant;
            end else begin
                state_d = S_BURST;
                owner_d = grant;
            end
        end else if (state_q == S_BURST) begin
            // Bubble inside a burst: hold Z and keep the burst's tag alive
            tag0_d = '{valid: 1'b1, first: 1'b0, last: 1'b0, id: owner_q};
        end
    end

    // Issue registers, tag pipeline aligned to the datapath, sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_b      <= '0;
            acc_addsub <= 1'b0;
            acc_sel    <= 1'b0;
            tag0_q     <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            ovf_acc_q  <= 1'b0;
        end else begin
            acc_b      <= b_d;
            acc_addsub <= sub_d;
            acc_sel    <= sel_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag0_q;
            tag2_q     <= tag1_q;
            if (tag2_q.valid) begin
                ovf_acc_q <= tag2_q.first ? acc_ovf : (ovf_acc_q | acc_ovf);
            end
        end
    end

    assign res_valid = tag2_q.valid & tag2_q.last;
    assign res_data  = res_valid ? acc_z : '0;
    assign res_ovf   = res_valid & ((~tag2_q.first & ovf_acc_q) | acc_ovf);
    assign res_id    = res_valid & tag2_q.id;

`ifdef ACC_BURST_ARBITER_BEATCNT_EN
    logic [7:0] beat_cnt_q;
    logic [7:0] cnt_next;
    logic [7:0] beats0_q, beats1_q;

    always_comb begin
        cnt_next = 8'd1;
        if (!first_beat) begin
            cnt_next = (beat_cnt_q == 8'hFF) ? 8'hFF : 8'(beat_cnt_q + 8'd1);
        end
    end

    // Count snapshot rides alongside the tag pipeline so it lines up with res_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            beats0_q   <= '0;
            beats1_q   <= '0;
            res_beats  <= '0;
        end else begin
            if (accept) begin
                beat_cnt_q <= cnt_next;
            end
            beats0_q  <= (accept && beat_last) ? cnt_next : 8'd0;
            beats1_q  <= beats0_q;
            res_beats <= beats1_q;
        end
    end
`endif

endmodule

// File: tb/tb_acc_burst_arbiter.sv
// Directed bench for acc_burst_arbiter with a behavioural accumulator datapath and a result scoreboard.
module tb_acc_burst_arbiter;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         r0_valid = 1'b0, r0_sub = 1'b0, r0_last = 1'b0;
    logic [N-1:0] r0_data = '0;
    logic         r1_valid = 1'b0, r1_sub = 1'b0, r1_last = 1'b0;
    logic [N-1:0] r1_data = '0;
    logic         r0_ready, r1_ready;
    logic [N-1:0] acc_a, acc_b, acc_z;
    logic         acc_sel, acc_addsub, acc_ovf;
    logic         res_valid, res_ovf, res_id;
    logic [N-1:0] res_data;
`ifdef ACC_BURST_ARBITER_BEATCNT_EN
    logic [7:0]   res_beats;
`endif

    acc_burst_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_sub(r0_sub), .r0_last(r0_last),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_sub(r1_sub), .r1_last(r1_last),
        .acc_a(acc_a), .acc_b(acc_b), .acc_sel(acc_sel), .acc_addsub(acc_addsub),
        .acc_z(acc_z), .acc_ovf(acc_ovf),
        .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
`ifdef ACC_BURST_ARBITER_BEATCNT_EN
        .res_beats(res_beats),
`endif
        .res_id(res_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // {overflow, result} of x +/- d in two's complement
    function automatic logic [N:0] addsub(input logic [N-1:0] x, input logic [N-1:0] d, input logic s);
        logic [N-1:0] r;
        logic         o;
        r = s ? N'(x - d) : N'(x + d);
        o = s ? ((x[N-1] != d[N-1]) && (r[N-1] != x[N-1]))
              : ((x[N-1] == d[N-1]) && (r[N-1] != x[N-1]));
        return {o, r};
    endfunction

    // Behavioural datapath: input registers then Z register, Sel=0 selects A
    logic [N-1:0] a_r, b_r, z_r;
    logic         sel_r, as_r, zo_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0; b_r <= '0; sel_r <= 1'b0; as_r <= 1'b0; z_r <= '0; zo_r <= 1'b0;
        end else begin
            a_r <= acc_a; b_r <= acc_b; sel_r <= acc_sel; as_r <= acc_addsub;
            {zo_r, z_r} <= addsub(sel_r ? z_r : a_r, b_r, as_r);
        end
    end
    assign acc_z   = z_r;
    assign acc_ovf = zo_r;

    typedef struct {
        int           id;
        logic [N-1:0] data;
        logic         ovf;
        int           beats;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           acc_id_q[$];
    int           acc_cyc_q[$];
    logic [N-1:0] msum[2];
    logic         movf[2];
    int           mcnt[2];
    bit           in_burst[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (sbq.size() == 0) begin
                chk("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_latency", 32'(cyc), 32'(e.cyc));
`ifdef ACC_BURST_ARBITER_BEATCNT_EN
                chk("res_beats", 32'(res_beats), 32'(e.beats));
`endif
            end
        end
    end

    // Model update for an accepted beat; pushes the expected result on the last beat
    task automatic record(input int id, input logic [N-1:0] d, input logic s, input logic l, input int c);
        logic [N:0] r;
        bit         f;
        exp_t       e;
        f = !in_burst[id];
        r = addsub(f ? '0 : msum[id], d, s);
        msum[id] = r[N-1:0];
        movf[id] = f ? r[N] : (movf[id] | r[N]);
        mcnt[id] = f ? 1 : ((mcnt[id] >= 255) ? 255 : mcnt[id] + 1);
        acc_id_q.push_back(id);
        acc_cyc_q.push_back(c);
        if (l) begin
            e.id = id; e.data = msum[id]; e.ovf = movf[id]; e.beats = mcnt[id]; e.cyc = c + 3;
            sbq.push_back(e);
        end
        in_burst[id] = !l;
    endtask

    // Present one beat and hold it until accepted; entered and left at posedge+1
    task automatic beat(input int id, input logic [N-1:0] d, input logic s, input logic l);
        bit got;
        got = 0;
        if (id == 0) begin r0_valid = 1'b1; r0_data = d; r0_sub = s; r0_last = l; end
        else         begin r1_valid = 1'b1; r1_data = d; r1_sub = s; r1_last = l; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? r0_ready : r1_ready;
            if (got) record(id, d, s, l, cyc);
            @(posedge clk);
        end
        #1;
        if (id == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
        if (!got) chk("beat_timeout", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_burst[0] = 0;
        in_burst[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_c;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_ovf", 32'(res_ovf), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_acc_a", 32'(acc_a), 32'd0);
        chk("rst_acc_b", 32'(acc_b), 32'd0);
        chk("rst_acc_sel", 32'(acc_sel), 32'd0);
        chk("rst_acc_addsub", 32'(acc_addsub), 32'd0);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(r1_ready), 32'd0);
`ifdef ACC_BURST_ARBITER_BEATCNT_EN
        chk("rst_res_beats", 32'(res_beats), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain three-beat burst: 5 + 7 - 3
        beat(0, 16'd5, 1'b0, 1'b0);
        beat(0, 16'd7, 1'b0, 1'b0);
        beat(0, 16'd3, 1'b1, 1'b1);
        drain();

        // Single-beat subtract from requester 1
        beat(1, 16'd4, 1'b1, 1'b1);
        drain();

        // Overflow on beat 2 stays sticky
        beat(0, 16'h7FFF, 1'b0, 1'b0);
        beat(0, 16'h0001, 1'b0, 1'b0);
        beat(0, 16'h0001, 1'b1, 1'b1);
        drain();
        beat(0, 16'h7FFF, 1'b0, 1'b0);
        beat(0, 16'h0001, 1'b0, 1'b0);
        beat(0, 16'h7FFF, 1'b0, 1'b1);
        drain();

        // Bubbles inside a burst hold Z; requester 1 waits for the burst to close
        fork
            begin
                beat(0, 16'd10, 1'b0, 1'b0);
                repeat (3) begin
                    @(negedge clk);
                    chk("bubble_r1_ready", 32'(r1_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                chk("bubble_z_hold", 32'(acc_z), 32'd10);
                chk("bubble_acc_b", 32'(acc_b), 32'd0);
                chk("bubble_acc_sel", 32'(acc_sel), 32'd1);
                beat(0, 16'd2, 1'b0, 1'b1);
            end
            begin
                @(posedge clk);
                #1;
                beat(1, 16'd3, 1'b0, 1'b1);
            end
        join
        drain();

        // Both requesters contending from reset: alternating back-to-back bursts
        do_reset();
        acc_id_q.delete();
        acc_cyc_q.delete();
        fork
            begin
                beat(0, 16'd1, 1'b0, 1'b0); beat(0, 16'd2, 1'b0, 1'b1);
                beat(0, 16'd3, 1'b0, 1'b0); beat(0, 16'd4, 1'b0, 1'b1);
            end
            begin
                beat(1, 16'd10, 1'b0, 1'b0); beat(1, 16'd20, 1'b0, 1'b1);
                beat(1, 16'd30, 1'b0, 1'b0); beat(1, 16'd40, 1'b0, 1'b1);
            end
        join
        drain();
        chk("rr_beat_count", 32'(acc_id_q.size()), 32'd8);
        if (acc_id_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("rr_order_%0d", i), 32'(acc_id_q[i]), 32'((i / 2) % 2));
            end
            first_c = acc_cyc_q[0];
            chk("rr_no_gap", 32'(acc_cyc_q[7] - first_c), 32'd7);
        end

        // Reset mid-burst abandons the burst
        beat(0, 16'd1, 1'b0, 1'b0);
        beat(0, 16'd1, 1'b0, 1'b0);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("abandon_no_result", 32'(sbq.size()), 32'd0);
        beat(1, 16'd1, 1'b0, 1'b1);
        drain();
        beat(0, 16'd1, 1'b0, 1'b0);
        beat(0, 16'd2, 1'b0, 1'b0);
        beat(0, 16'd3, 1'b0, 1'b0);
        beat(0, 16'd4, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
